// File: rtl/program_run_ctrl.sv
// Run controller in front of the single-cycle core: sequences core reset, then
// watches the PC for a checkpoint, end of program and the watchdog.
module program_run_ctrl #(
    parameter int unsigned WDOG_LIMIT = 255,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        start,
    input  logic [63:0] start_pc_in,
    input  logic [63:0] end_pc,
    input  logic [63:0] chk_pc,
    input  logic [63:0] chk_value,
    input  logic [63:0] final_value,
    input  logic [63:0] currentpc,
    input  logic [63:0] MemtoRegOut,
    output logic        cpu_resetl,
    output logic [63:0] startpc,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic        chk_fail,
    output logic [15:0] cycle_count,
    output logic [1:0]  dbg_state    // 0 IDLE, 1 RST, 2 RUN, 3 DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [15:0]    WDOG_LAST = 16'(WDOG_LIMIT - 1);

    state_t          state, state_n;
    logic [RCW-1:0]  rst_cnt, rst_cnt_n;
    logic [15:0]     cnt_n;
    logic [63:0]     spc_n;
    logic            chk_seen, seen_n, fail_n, pass_n, to_n;
    logic            pc_hit, pc_end, wdog_hit;

    assign pc_hit    = (currentpc == chk_pc);
    assign pc_end    = (currentpc >= end_pc);
    assign wdog_hit  = (cycle_count == WDOG_LAST);
    assign dbg_state = state;

    // start is a one-cycle request with no ready: it is accepted only in
    // IDLE or DONE and silently dropped while a run is in progress.
    always_comb begin
        state_n   = state;
        rst_cnt_n = rst_cnt;
        cnt_n     = cycle_count;
        spc_n     = startpc;
        seen_n    = chk_seen;
        fail_n    = chk_fail;
        pass_n    = pass;
        to_n      = timeout;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n   = S_RST;
                    spc_n     = start_pc_in;
                    rst_cnt_n = '0;
                    cnt_n     = '0;
                    seen_n    = 1'b0;
                    fail_n    = 1'b0;
                    pass_n    = 1'b0;
                    to_n      = 1'b0;
                end
            end
            S_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_n = S_RUN;
                end else begin
                    rst_cnt_n = rst_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // Checkpoint is folded in first so the terminating edge sees it.
                if (pc_hit) begin
                    seen_n = 1'b1;
                    if (MemtoRegOut != chk_value) fail_n = 1'b1;
                end
                if (pc_end) begin
                    state_n = S_DONE;
                    to_n    = 1'b0;
                    pass_n  = seen_n & ~fail_n & (MemtoRegOut == final_value);
                end else if (wdog_hit) begin
                    state_n = S_DONE;
                    to_n    = 1'b1;
                    pass_n  = 1'b0;
                    cnt_n   = cycle_count + 16'd1;
                end else begin
                    cnt_n = cycle_count + 16'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            startpc     <= '0;
            chk_seen    <= 1'b0;
            chk_fail    <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cpu_resetl  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            rst_cnt     <= rst_cnt_n;
            cycle_count <= cnt_n;
            startpc     <= spc_n;
            chk_seen    <= seen_n;
            chk_fail    <= fail_n;
            pass        <= pass_n;
            timeout     <= to_n;
            cpu_resetl  <= (state_n == S_RUN);
            busy        <= (state_n == S_RST) || (state_n == S_RUN);
            done        <= (state_n == S_DONE);
        end
    end

endmodule
